// File: rtl/mcac_pkg.sv
// Shared types and constants for the multi-channel ADPCM job sequencer.
package mcac_pkg;

   localparam int NUM_CH_DEFAULT = 32;
   localparam int TMO_W          = 10;

   localparam logic DIR_ENC = 1'b0;
   localparam logic DIR_DEC = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      START,
      WAIT,
      FDONE
   } sched_state_t;

endpackage

// File: rtl/mcac_timeout_cnt.sv
// Loadable saturating down-counter for handshake watchdogs; o_expired is high while the count is zero.
// Load has priority over decrement; clear has priority over load.
module mcac_timeout_cnt #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mcac_channel_sched.sv
// Walks every enabled channel once per frame, issuing an encode then a decode job to the shared datapath.
// First dp_start two cycles after frame_sync; a job ends on dp_done or after TIMEOUT cycles.
module mcac_channel_sched
   import mcac_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEFAULT,
   parameter int CH_W    = $clog2(NUM_CH),
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_sync,
   input  logic [NUM_CH-1:0] ch_enable,
   output logic              dp_start,
   output logic [CH_W-1:0]   dp_ch,
   output logic              dp_dir,
   input  logic              dp_done,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun,
   output logic              timeout_err,
   input  logic              err_clr,
   input  logic              scan_in0,
   input  logic              scan_in1,
   input  logic              scan_in2,
   input  logic              scan_in3,
   input  logic              scan_in4,
   input  logic              scan_enable,
   input  logic              test_mode,
   output logic              scan_out0,
   output logic              scan_out1,
   output logic              scan_out2,
   output logic              scan_out3,
   output logic              scan_out4
);

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   // The counter also ticks during START, so loading TIMEOUT-1 expires in the same cycle the count reaches TIMEOUT.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

   sched_state_t      r_state;
   logic [NUM_CH-1:0] r_en_q;
   logic [CH_W-1:0]   r_ch;
   logic              r_dir;
   logic              r_dp_start;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_overrun;
   logic              r_timeout_err;

   logic w_expired;
   logic w_last_ch;
   logic w_job_end;
   logic w_job_timeout;
   logic w_enter_start;
   logic w_cnt_en;
   logic w_cnt_clr;
   logic w_dft_en;

   assign w_last_ch     = (r_ch == LAST_CH);
   assign w_job_end     = (r_state == WAIT) && (dp_done || w_expired);
   assign w_job_timeout = (r_state == WAIT) && !dp_done && w_expired;
   assign w_enter_start = ((r_state == SCAN) && r_en_q[r_ch]) ||
                          (w_job_end && (r_dir == DIR_ENC));
   assign w_cnt_en      = (r_state == START) || (r_state == WAIT);
   assign w_cnt_clr     = (r_state == FDONE);

   mcac_timeout_cnt #(
      .W (TMO_W)
   ) u_timeout_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_cnt_clr),
      .i_load     (w_enter_start),
      .i_load_val (TMO_LOAD),
      .i_en       (w_cnt_en),
      .o_expired  (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_en_q        <= '0;
         r_ch          <= '0;
         r_dir         <= DIR_ENC;
         r_dp_start    <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_dp_start   <= 1'b0;
         r_frame_done <= 1'b0;

         // A new error event outranks a simultaneous clear.
         if (frame_sync && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end else if (err_clr) begin
            r_overrun <= 1'b0;
         end

         if (w_job_timeout) begin
            r_timeout_err <= 1'b1;
         end else if (err_clr) begin
            r_timeout_err <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (frame_sync) begin
                  r_en_q  <= ch_enable;
                  r_ch    <= '0;
                  r_dir   <= DIR_ENC;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (r_en_q[r_ch]) begin
                  r_dp_start <= 1'b1;
                  r_state    <= START;
               end else if (w_last_ch) begin
                  r_frame_done <= 1'b1;
                  r_state      <= FDONE;
               end else begin
                  r_ch <= r_ch + CH_W'(1);
               end
            end
            START: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_job_end) begin
                  if (r_dir == DIR_ENC) begin
                     r_dir      <= DIR_DEC;
                     r_dp_start <= 1'b1;
                     r_state    <= START;
                  end else begin
                     r_dir <= DIR_ENC;
                     if (w_last_ch) begin
                        r_frame_done <= 1'b1;
                        r_state      <= FDONE;
                     end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= SCAN;
                     end
                  end
               end
            end
            FDONE: begin
               r_busy  <= 1'b0;
               r_ch    <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign dp_start    = r_dp_start;
   assign dp_ch       = r_ch;
   assign dp_dir      = r_dir;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign overrun     = r_overrun;
   assign timeout_err = r_timeout_err;

   // Scan ports gated by scan_enable and test_mode; functional logic does not use them.
   assign w_dft_en  = scan_enable & test_mode;
   assign scan_out0 = w_dft_en & scan_in0;
   assign scan_out1 = w_dft_en & scan_in1;
   assign scan_out2 = w_dft_en & scan_in2;
   assign scan_out3 = w_dft_en & scan_in3;
   assign scan_out4 = w_dft_en & scan_in4;

endmodule
